// File: rtl/input_conditioner.sv
// input_conditioner: front-end for switch levels and push-buttons.
// Nine independent channels (7 levels + 2 buttons), each passing through a
// 2-flop synchronizer, a debounce counter and a stable register.
// Buttons additionally produce one-cycle registered strobes on a debounced
// rising edge.
// Optional feature: define PULSE_AUTOREPEAT_EN to emit repeat strobes every
// REPEAT_CYCLES cycles while a debounced button stays high.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] raw_levels,
  input  logic [1:0] raw_buttons,
  output logic [6:0] levels,
  output logic       pulse_3,
  output logic       pulse_2,
  output logic       inputs_settled
);

  localparam int unsigned NCH = 9;
  localparam int unsigned BTN_BASE = 7;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter only needs to hold DEBOUNCE_CYCLES-1; reaching that value
  // with another mismatch commits the change, so the counter never wraps.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_param_check
    $error("input_conditioner: parameter out of legal range");
  end

  logic [NCH-1:0]         raw_all;
  logic [NCH-1:0]         sync1_q, sync1_d;
  logic [NCH-1:0]         sync2_q, sync2_d;
  logic [NCH-1:0]         stable_q, stable_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]             pulse_q, pulse_d;
  logic [1:0]             rise;
  logic                   settled;

  assign raw_all = {raw_buttons, raw_levels};

  // Synchronizer shift and per-channel debounce decision.
  always_comb begin
    sync1_d  = raw_all;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      if (sync2_q[ch] != stable_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          stable_d[ch] = sync2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  // Debounced button rising edges, taken from the value being committed so
  // the strobe register loads on the same edge as the stable register.
  always_comb begin
    rise = stable_d[BTN_BASE +: 2] & ~stable_q[BTN_BASE +: 2];
  end

`ifdef PULSE_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [1:0][RW-1:0] rep_q, rep_d;

  // Strobe on press, then every REPEAT_CYCLES cycles while held.
  always_comb begin
    rep_d   = '0;
    pulse_d = rise;
    for (int unsigned b = 0; b < 2; b++) begin
      if (stable_q[BTN_BASE + b] && stable_d[BTN_BASE + b]) begin
        if (rep_q[b] == REP_LAST) begin
          pulse_d[b] = 1'b1;
        end else begin
          rep_d[b] = rep_q[b] + RW'(1);
        end
      end
    end
  end

  // Auto-repeat counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  // Single strobe per debounced press.
  always_comb begin
    pulse_d = rise;
  end
`endif

  // Quiet when nothing is in flight on any channel.
  always_comb begin
    settled = (sync2_q == stable_q);
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      if (cnt_q[ch] != '0) begin
        settled = 1'b0;
      end
    end
  end

  // Channel state and strobe registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      pulse_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign levels         = stable_q[6:0];
  assign pulse_2        = pulse_q[0];
  assign pulse_3        = pulse_q[1];
  assign inputs_settled = settled;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Reference model works on the history of raw samples: a channel output flips
// once the most recent DEBOUNCE_CYCLES synchronized samples all disagree with it.
module tb_input_conditioner;

  localparam int DEB = 4;
  localparam int REP = 8;

  logic       clock;
  logic       reset;
  logic [6:0] raw_levels;
  logic [1:0] raw_buttons;
  logic [6:0] levels;
  logic       pulse_3;
  logic       pulse_2;
  logic       inputs_settled;

  int n_checks;
  int n_fail;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .raw_levels    (raw_levels),
    .raw_buttons   (raw_buttons),
    .levels        (levels),
    .pulse_3       (pulse_3),
    .pulse_2       (pulse_2),
    .inputs_settled(inputs_settled)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  logic [8:0] hist[$];
  logic [8:0] m_stab;
  logic [1:0] m_pulse;
  logic       m_settled;
  int         m_held[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(9'h000);
    m_stab    = '0;
    m_pulse   = '0;
    m_settled = 1'b1;
    m_held[0] = 0;
    m_held[1] = 0;
  endtask

  // One rising edge sampling 'raw'; raw@(edge-2) is what the debouncer sees.
  task automatic model_edge(input logic [8:0] raw);
    logic [8:0] nxt;
    int n;
    bit all_diff;
    hist.push_back(raw);
    if (hist.size() > 64) void'(hist.pop_front());
    n = hist.size();
    nxt = m_stab;
    for (int ch = 0; ch < 9; ch++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (hist[n - 3 - k][ch] == m_stab[ch]) all_diff = 1'b0;
      if (all_diff) nxt[ch] = ~m_stab[ch];
    end
    for (int b = 0; b < 2; b++) begin
      m_pulse[b] = !m_stab[7 + b] && nxt[7 + b];
`ifdef PULSE_AUTOREPEAT_EN
      if (m_pulse[b]) m_held[b] = 0;
      else if (m_stab[7 + b] && nxt[7 + b]) begin
        m_held[b]++;
        if (m_held[b] % REP == 0) m_pulse[b] = 1'b1;
      end else m_held[b] = 0;
`endif
    end
    m_settled = 1'b1;
    for (int ch = 0; ch < 9; ch++)
      if (hist[n - 2][ch] != nxt[ch] || hist[n - 3][ch] != nxt[ch]) m_settled = 1'b0;
    m_stab = nxt;
  endtask

  task automatic step(input logic [6:0] lv, input logic [1:0] bt);
    raw_levels  = lv;
    raw_buttons = bt;
    @(posedge clock);
    model_edge({bt, lv});
    #1;
    check("levels",  32'(levels),         32'(m_stab[6:0]));
    check("pulse_2", 32'(pulse_2),        32'(m_pulse[0]));
    check("pulse_3", 32'(pulse_3),        32'(m_pulse[1]));
    check("settled", 32'(inputs_settled), 32'(m_settled));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_levels"},  32'(levels),         32'd0);
    check({tag, "_pulses"},  32'({pulse_3, pulse_2}), 32'd0);
    check({tag, "_settled"}, 32'(inputs_settled), 32'd1);
  endtask

  // Asserted and released 1 time unit after a rising edge.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("rst_async");
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      check_reset_outputs("rst_hold");
    end
    reset = 1'b0;
  endtask

  initial begin
    int p2_cnt, p3_cnt, both_cnt;
    logic [6:0] lv;
    logic [1:0] bt;
    int hold;

    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    raw_levels  = '0;
    raw_buttons = '0;
    model_reset();
    @(posedge clock);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Single level held: output at edge 6, settled low on edges 2..5.
    for (int e = 1; e <= 8; e++) begin
      step(7'b0000001, 2'b00);
      check("lvl0_latency", 32'(levels[0]), 32'(e >= 6));
      check("lvl0_settled", 32'(inputs_settled), 32'(!(e >= 2 && e <= 5)));
    end
    for (int e = 0; e < 8; e++) step(7'b0000000, 2'b00);

    // Glitch train shorter than the debounce window.
    begin
      logic [5:0] pat;
      pat = 6'b011101;
      for (int i = 0; i < 6; i++) begin
        step({5'b0, pat[i], 1'b0}, 2'b00);
        check("glitch_lvl1", 32'(levels[1]), 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
        step(7'b0, 2'b00);
        check("glitch_lvl1", 32'(levels[1]), 32'd0);
      end
    end

    // Both buttons held 20 cycles.
    p2_cnt = 0; p3_cnt = 0; both_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(7'b0, 2'b11);
      p2_cnt += int'(pulse_2);
      p3_cnt += int'(pulse_3);
      both_cnt += int'(pulse_2 && pulse_3);
    end
`ifdef PULSE_AUTOREPEAT_EN
    check("btn_p2_count", 32'(p2_cnt), 32'd2);
    check("btn_p3_count", 32'(p3_cnt), 32'd2);
    check("btn_same_cycle", 32'(both_cnt), 32'd2);
`else
    check("btn_p2_count", 32'(p2_cnt), 32'd1);
    check("btn_p3_count", 32'(p3_cnt), 32'd1);
    check("btn_same_cycle", 32'(both_cnt), 32'd1);
`endif
    p2_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'b0, 2'b00);
      p2_cnt += int'(pulse_2 || pulse_3);
    end
    check("btn_release_nopulse", 32'(p2_cnt), 32'd0);

    // Reset mid-hold of button 2, still held after release.
    for (int i = 0; i < 3; i++) step(7'b0, 2'b01);
    do_reset(2);
    for (int e = 1; e <= 9; e++) begin
      step(7'b0, 2'b01);
      check("rst_btn_pulse", 32'(pulse_2), 32'(e == 6));
    end
    for (int i = 0; i < 8; i++) step(7'b0, 2'b00);

    // All levels up for 10 cycles, then down.
    for (int e = 1; e <= 10; e++) begin
      step(7'h7F, 2'b00);
      check("all_up", 32'(levels), (e >= 6) ? 32'h7F : 32'h00);
      check("all_up_nopulse", 32'({pulse_3, pulse_2}), 32'd0);
    end
    for (int e = 1; e <= 8; e++) begin
      step(7'h00, 2'b00);
      check("all_down", 32'(levels), (e >= 6) ? 32'h00 : 32'h7F);
    end

    // Randomized bursts with occasional resets.
    lv = '0; bt = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end
      lv = lv ^ 7'($urandom_range(0, 127) & $urandom_range(0, 127));
      bt = bt ^ 2'($urandom_range(0, 3) & $urandom_range(0, 3));
      hold = int'($urandom_range(1, 7));
      for (int h = 0; h < hold; h++) step(lv, bt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
